// File: rtl/mc_main_controller.sv
// -----------------------------------------------------------------------------
// mc_main_controller
//   Multicycle MIPS main controller. A Moore FSM sequences each instruction over
//   3-5 cycles (plus memory wait states) and drives the datapath enables and
//   mux selects. It also flags unknown opcodes (sticky until reset) and exports
//   the current state index for debug.
//
//   Optional feature macro: MC_CTRL_BNE_EN
//     When defined, opcode 000101 (bne) is decoded into state BNE (index 12)
//     and the extra output BranchNe is present. When undefined, bne is illegal.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous reset, active-high
//   opcode      in   IR[31:26], sampled in DECODE (and MEMADR for lw/sw split)
//   mem_ready   in   memory access completes this cycle
//   PCWrite     out  unconditional PC update
//   Branch      out  PC update if ALU Zero
//   IorD        out  memory address select (0 PC, 1 ALUOut)
//   IRWrite     out  instruction register load
//   MemWrite    out  memory write strobe
//   RegWrite    out  register file write
//   RegDst      out  write register select (0 rt, 1 rd)
//   MemToReg    out  writeback data select (0 ALUOut, 1 MDR)
//   ALUSrcA     out  ALU A select (0 PC, 1 rs)
//   ALUSrcB     out  ALU B select (00 rt, 01 4, 10 SignImm, 11 SignImm<<2)
//   ALUOp       out  ALU decoder mode (00 add, 01 sub, 10 funct)
//   PCSrc       out  PC source (00 ALU result, 01 ALUOut, 10 jump target)
//   BranchNe    out  PC update if ALU Zero is 0 (only with MC_CTRL_BNE_EN)
//   illegal_op  out  sticky unknown-opcode flag
//   state_o     out  current state index
// -----------------------------------------------------------------------------
module mc_main_controller #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                Branch,
    output logic                IorD,
    output logic                IRWrite,
    output logic                MemWrite,
    output logic                RegWrite,
    output logic                RegDst,
    output logic                MemToReg,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [1:0]          PCSrc,
`ifdef MC_CTRL_BNE_EN
    output logic                BranchNe,
`endif
    output logic                illegal_op,
    output logic [STATE_W-1:0]  state_o
);

    localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXEC   = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_ALUWB  = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_BEQ    = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_ADDIEX = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_ADDIWB = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_JUMP   = STATE_W'(11);
`ifdef MC_CTRL_BNE_EN
    localparam logic [STATE_W-1:0] S_BNE    = STATE_W'(12);
`endif

    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_RTYP = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);
`ifdef MC_CTRL_BNE_EN
    localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'b000101);
`endif

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(2'b00);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2'b01);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2'b10);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_next;
    logic               r_illegal;
    logic               w_illegal_dec;

    // State register and sticky illegal-opcode flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_illegal_dec) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next  = S_FETCH;
        w_illegal_dec = 1'b0;
        case (r_state)
            S_FETCH:  w_state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_state_next = S_MEMADR;
                    OP_RTYP:      w_state_next = S_EXEC;
                    OP_BEQ:       w_state_next = S_BEQ;
                    OP_ADDI:      w_state_next = S_ADDIEX;
                    OP_J:         w_state_next = S_JUMP;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       w_state_next = S_BNE;
`endif
                    default: begin
                        w_state_next  = S_FETCH;
                        w_illegal_dec = 1'b1;
                    end
                endcase
            end
            // IR holds the opcode, so the lw/sw split is re-read here.
            S_MEMADR: begin
                if (opcode == OP_LW) begin
                    w_state_next = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    w_state_next = S_MEMWR;
                end else begin
                    w_state_next = S_FETCH;
                end
            end
            S_MEMRD:  w_state_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_state_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_state_next = S_ALUWB;
            S_ADDIEX: w_state_next = S_ADDIWB;
            default:  w_state_next = S_FETCH;  // writeback/branch/jump and unused codes
        endcase
    end

    // Output logic (Moore, except the FETCH handshake which gates on mem_ready).
    always_comb begin
        PCWrite  = 1'b0;
        Branch   = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        MemToReg = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = ALU_ADD;
        PCSrc    = 2'b00;
`ifdef MC_CTRL_BNE_EN
        BranchNe = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                ALUSrcB = 2'b01;
                // PC and IR load only on the completing cycle, so wait states
                // never advance the PC more than once.
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD:  IorD = 1'b1;
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_SUB;
                PCSrc   = 2'b01;
                Branch  = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
            end
`ifdef MC_CTRL_BNE_EN
            S_BNE: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALU_SUB;
                PCSrc    = 2'b01;
                BranchNe = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign illegal_op = r_illegal;
    assign state_o    = r_state;

endmodule
